// File: rtl/ram_arbiter.sv
// Shares one registered-read RAM port among NUM_CORES requesters, one transaction per four cycles.
// Round-robin by default; define ARB_FIXED_PRIORITY_EN for lowest-index-wins selection.
module ram_arbiter #(
   parameter int unsigned NUM_CORES  = 4,
   parameter int unsigned DATA_WIDTH = 12,
   parameter int unsigned DEPTH      = 256,
   localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_CORES-1:0]             core_req,
   input  logic [NUM_CORES-1:0]             core_wrEn,
   input  logic [NUM_CORES*ADDR_WIDTH-1:0]  core_address,
   input  logic [NUM_CORES*DATA_WIDTH-1:0]  core_dataIn,
   output logic [NUM_CORES-1:0]             core_done,
   output logic [DATA_WIDTH-1:0]            core_dataOut,
   output logic                             busy,
   output logic                             mem_wrEn,
   output logic [ADDR_WIDTH-1:0]            mem_address,
   output logic [DATA_WIDTH-1:0]            mem_dataIn,
   input  logic [DATA_WIDTH-1:0]            mem_dataOut
);

   localparam int unsigned IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } state_e;

   state_e                  state_q;
   logic [IDX_W-1:0]        grant_q;
   logic [IDX_W-1:0]        grant_d;
   logic                    grant_vld_d;
   logic                    busy_q;
   logic [NUM_CORES-1:0]    done_q;
   logic [NUM_CORES-1:0]    done_d;
   logic                    mem_we_q;
   logic [ADDR_WIDTH-1:0]   mem_addr_q;
   logic [DATA_WIDTH-1:0]   mem_wdata_q;
   logic [DATA_WIDTH-1:0]   rdata_q;
   logic                    sel_wr_d;
   logic [ADDR_WIDTH-1:0]   sel_addr_d;
   logic [DATA_WIDTH-1:0]   sel_data_d;

`ifdef ARB_FIXED_PRIORITY_EN
   // Lowest requesting index wins; no rotation state.
   always_comb begin
      grant_d     = '0;
      grant_vld_d = 1'b0;
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
         if (!grant_vld_d && core_req[IDX_W'(i)]) begin
            grant_d     = IDX_W'(i);
            grant_vld_d = 1'b1;
         end
      end
   end
`else
   logic [IDX_W-1:0] rr_ptr_q;
   logic [IDX_W-1:0] rr_ptr_d;

   // Core index reached by stepping ofs places from ptr, wrapping at NUM_CORES.
   function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] ptr,
                                               input int unsigned      ofs);
      int unsigned k;
      k = 32'(ptr) + ofs;
      if (k >= NUM_CORES) k = k - NUM_CORES;
      return IDX_W'(k);
   endfunction

   // First requester at or after rr_ptr wins.
   always_comb begin
      grant_d     = '0;
      grant_vld_d = 1'b0;
      for (int unsigned ofs = 0; ofs < NUM_CORES; ofs++) begin
         if (!grant_vld_d && core_req[rr_idx(rr_ptr_q, ofs)]) begin
            grant_d     = rr_idx(rr_ptr_q, ofs);
            grant_vld_d = 1'b1;
         end
      end
      rr_ptr_d = (grant_d == IDX_W'(NUM_CORES - 1)) ? '0 : grant_d + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q <= '0;
      end else if (state_q == IDLE && grant_vld_d) begin
         rr_ptr_q <= rr_ptr_d;
      end
   end
`endif

   // Route the winning core's command fields.
   always_comb begin
      sel_wr_d   = 1'b0;
      sel_addr_d = '0;
      sel_data_d = '0;
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
         if (grant_d == IDX_W'(i)) begin
            sel_wr_d   = core_wrEn[i];
            sel_addr_d = core_address[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_data_d = core_dataIn[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      done_d = '0;
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
         done_d[i] = (grant_q == IDX_W'(i));
      end
   end

   // Transaction sequencer; every output is registered on the edge entering its state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rdata_q     <= '0;
      end else begin
         mem_we_q <= 1'b0;
         done_q   <= '0;
         case (state_q)
            IDLE: begin
               if (grant_vld_d) begin
                  state_q     <= ISSUE;
                  grant_q     <= grant_d;
                  busy_q      <= 1'b1;
                  mem_we_q    <= sel_wr_d;
                  mem_addr_q  <= sel_addr_d;
                  mem_wdata_q <= sel_data_d;
               end
            end
            ISSUE: begin
               state_q <= CAPTURE;
            end
            CAPTURE: begin
               // Write-first RAM: a write returns the new word here too.
               state_q <= DONE;
               rdata_q <= mem_dataOut;
               done_q  <= done_d;
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign core_done    = done_q;
   assign core_dataOut = rdata_q;
   assign busy         = busy_q;
   assign mem_wrEn     = mem_we_q;
   assign mem_address  = mem_addr_q;
   assign mem_dataIn   = mem_wdata_q;

endmodule
